// File: rtl/sync_launch_pkg.sv
// -----------------------------------------------------------------------------
// sync_launch_pkg
// Shared definitions for the synchronizer word launcher:
//   launch_state_t  - launcher FSM states
//   cnt_width()     - bits needed to hold a counter value 0..max_val
//   DATA_RESET_BIT  - reset value replicated across the launched-data register
// -----------------------------------------------------------------------------
package sync_launch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } launch_state_t;

    localparam logic DATA_RESET_BIT = 1'b0;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_word_launcher_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small first-word-fall-through FIFO. The head word is visible combinationally
// so the launcher can capture it in the same cycle it pops.
// Ports:
//   clk, reset_n       - clock, synchronous active-low reset (empties FIFO)
//   i_push, i_push_data- write request/data (ignored when full)
//   i_pop              - remove head word (ignored when empty)
//   o_head             - current head word
//   o_full, o_empty    - status flags
//   o_count            - number of words stored
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_BIT_WIDTH = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_push,
    input  logic [DATA_BIT_WIDTH-1:0]     i_push_data,
    input  logic                          i_pop,
    output logic [DATA_BIT_WIDTH-1:0]     o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic                      w_push_ok;
    logic                      w_pop_ok;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sync_word_launcher.sv
// -----------------------------------------------------------------------------
// sync_word_launcher
// Source-side launcher for a 3-stage enable/ack synchronizer. Buffers words in
// a FIFO and presents them one at a time on sync_d_o with sync_en_o, holding
// the word until the destination confirms with rx_done_i (already
// synchronized into this domain) or a timeout drops it.
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   wr_valid_i/wr_data_i/wr_ready_o - local write interface
//   sync_en_o, sync_d_o  - synchronizer enable and data (registered)
//   sync_ack_i     - synchronizer enable_ack
//   rx_done_i      - destination reception acknowledge (level or pulse)
//   busy_o         - FSM active or words buffered
//   timeout_o      - one-cycle pulse when a word is dropped
//   fifo_count_o   - words currently buffered
// -----------------------------------------------------------------------------
module sync_word_launcher
    import sync_launch_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLD_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_valid_i,
    input  logic [DATA_BIT_WIDTH-1:0]     wr_data_i,
    output logic                          wr_ready_o,
    output logic                          sync_en_o,
    output logic [DATA_BIT_WIDTH-1:0]     sync_d_o,
    input  logic                          sync_ack_i,
    input  logic                          rx_done_i,
    output logic                          busy_o,
    output logic                          timeout_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    generate
        if (DATA_BIT_WIDTH <= 1) begin : g_bad_width
            $error("sync_word_launcher: DATA_BIT_WIDTH must be greater than 1");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_word_launcher: FIFO_DEPTH must be a power of two and at least 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("sync_word_launcher: HOLD_CYCLES must be at least 1");
        end
        if (TIMEOUT_CYCLES <= HOLD_CYCLES + 1) begin : g_bad_timeout
            $error("sync_word_launcher: TIMEOUT_CYCLES must exceed HOLD_CYCLES+1");
        end
    endgenerate

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int TMO_W  = cnt_width(TIMEOUT_CYCLES);
    // Comparing against "last" values lets the transition fire on the cycle
    // the counter would reach its target, so the registered output changes
    // on the following cycle.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    launch_state_t               r_state, w_state_next;
    logic [HOLD_W-1:0]           r_hold, w_hold_next;
    logic [TMO_W-1:0]            r_tmo, w_tmo_next;
    logic                        r_en, w_en_next;
    logic [DATA_BIT_WIDTH-1:0]   r_data, w_data_next;
    logic                        r_timeout, w_timeout_next;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_pop;
    logic [DATA_BIT_WIDTH-1:0]   w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    sync_fifo #(
        .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (wr_valid_i),
        .i_push_data (wr_data_i),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_tmo     <= '0;
            r_en      <= 1'b0;
            r_data    <= {DATA_BIT_WIDTH{DATA_RESET_BIT}};
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_hold    <= w_hold_next;
            r_tmo     <= w_tmo_next;
            r_en      <= w_en_next;
            r_data    <= w_data_next;
            r_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_hold_next    = r_hold;
        w_tmo_next     = r_tmo;
        w_en_next      = 1'b0;
        w_data_next    = r_data;
        w_timeout_next = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_data_next  = w_head;
                    w_en_next    = 1'b1;
                    w_hold_next  = '0;
                    w_tmo_next   = '0;
                    w_state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                w_en_next  = 1'b1;
                w_tmo_next = r_tmo + TMO_W'(1);
                // rx_done_i is deliberately not looked at here: the hold
                // must complete even if the destination answers early.
                if (r_tmo == TMO_LAST) begin
                    w_en_next      = 1'b0;
                    w_timeout_next = 1'b1;
                    w_state_next   = GAP;
                end else if (sync_ack_i) begin
                    w_hold_next = r_hold + HOLD_W'(1);
                    if (r_hold == HOLD_LAST) begin
                        w_en_next    = 1'b0;
                        w_state_next = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                w_tmo_next = r_tmo + TMO_W'(1);
                // A done arriving on the timeout cycle still counts as success.
                if (rx_done_i) begin
                    w_state_next = GAP;
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = GAP;
                end
            end
            GAP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign wr_ready_o   = !w_full;
    assign busy_o       = (r_state != IDLE) || !w_empty;
    assign sync_en_o    = r_en;
    assign sync_d_o     = r_data;
    assign timeout_o    = r_timeout;
    assign fifo_count_o = w_count;

endmodule

// File: tb/tb_sync_word_launcher.sv
module tb_sync_word_launcher;

    localparam int W       = 3;
    localparam int DEPTH   = 4;
    localparam int HOLD    = 3;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         wr_valid_i = 1'b0;
    logic [W-1:0] wr_data_i = '0;
    logic         wr_ready_o;
    logic         sync_en_o;
    logic [W-1:0] sync_d_o;
    logic         sync_ack_i = 1'b0;
    logic         rx_done_i = 1'b0;
    logic         busy_o;
    logic         timeout_o;
    logic [$clog2(DEPTH):0] fifo_count_o;

    sync_word_launcher #(
        .DATA_BIT_WIDTH (W),
        .FIFO_DEPTH     (DEPTH),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_valid_i   (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .wr_ready_o   (wr_ready_o),
        .sync_en_o    (sync_en_o),
        .sync_d_o     (sync_d_o),
        .sync_ack_i   (sync_ack_i),
        .rx_done_i    (rx_done_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    // Responder controls: ack follows enable by one cycle; done either held
    // high, or pulsed done_delay cycles after the enable falls (0 = never).
    bit prev_en = 1'b0;
    bit done_level = 1'b0;
    int done_delay = 0;
    int fall_cyc = -1000;
    int launched[$];

    // Behavioural model: buffered words, plus the life of the word in flight
    // described by its age and number of acknowledged hold cycles.
    int mq[$];
    bit m_word = 0;   // a word owns the synchronizer
    bit m_gap  = 0;   // mandatory low-enable cycle after a word
    int m_age  = 0;
    int m_acks = 0;
    bit m_en   = 0;
    int m_d    = 0;
    bit m_to   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic m_drop();
        m_to = 1; m_en = 0; m_word = 0; m_gap = 1;
    endtask

    task automatic model_step();
        bit push;
        if (!reset_n) begin
            mq.delete();
            m_word = 0; m_gap = 0; m_en = 0; m_d = 0; m_to = 0;
            return;
        end
        push = wr_valid_i && (mq.size() < DEPTH);
        m_to = 0;
        if (m_gap) begin
            m_gap = 0;
        end else if (!m_word) begin
            if (mq.size() != 0) begin
                m_d = mq.pop_front();
                m_word = 1; m_age = 0; m_acks = 0; m_en = 1;
            end
        end else begin
            m_age++;
            if (m_acks < HOLD) begin
                if (m_age >= TIMEOUT) m_drop();
                else if (sync_ack_i) begin
                    m_acks++;
                    if (m_acks == HOLD) m_en = 0;
                end
            end else if (rx_done_i) begin
                m_word = 0; m_gap = 1;
            end else if (m_age >= TIMEOUT) begin
                m_drop();
            end
        end
        if (push) mq.push_back(int'(wr_data_i));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        sync_ack_i = prev_en;
        if (prev_en && !sync_en_o) fall_cyc = cyc;
        if (!prev_en && sync_en_o) begin
            launched.push_back(int'(sync_d_o));
            $display("launch word=%0d cycle=%0d", sync_d_o, cyc);
        end
        rx_done_i = done_level || (done_delay > 0 && cyc == fall_cyc + done_delay);
        prev_en = sync_en_o;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 300) begin
            tick();
            n++;
        end
        check(name, int'(busy_o), 0);
        repeat (2) tick();
    endtask

    task automatic new_test(input int delay, input bit level);
        done_delay = delay;
        done_level = level;
        rx_done_i  = level;
        fall_cyc   = -1000;
        cyc        = 0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("en",      int'(sync_en_o),    int'(m_en));
            check("data",    int'(sync_d_o),     m_d);
            check("timeout", int'(timeout_o),    int'(m_to));
            check("count",   int'(fifo_count_o), mq.size());
            check("ready",   int'(wr_ready_o),   int'(mq.size() < DEPTH));
            check("busy",    int'(busy_o),       int'(m_word || m_gap || mq.size() != 0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        reset_n = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        reset_n = 1'b1;
        check("rst_en", int'(sync_en_o), 0);
        check("rst_count", int'(fifo_count_o), 0);
        check("rst_ready", int'(wr_ready_o), 1);
        check("rst_busy", int'(busy_o), 0);
        tick();

        // 1: single word, done 4 cycles after enable falls
        new_test(4, 0);
        wr_valid_i = 1; wr_data_i = 3'b101;
        tick(); wr_valid_i = 0;
        check("t1_en_c1", int'(sync_en_o), 0);
        goto(2);
        check("t1_en_c2", int'(sync_en_o), 1);
        check("t1_d_c2", int'(sync_d_o), 5);
        goto(5); check("t1_en_c5", int'(sync_en_o), 1);
        goto(6); check("t1_en_c6", int'(sync_en_o), 0);
        check("t1_d_c6", int'(sync_d_o), 5);
        goto(11); check("t1_busy_gap", int'(busy_o), 1);
        goto(12); check("t1_busy_idle", int'(busy_o), 0);
        check("t1_d_hold", int'(sync_d_o), 5);
        wait_idle("t1_drain");

        // 2: burst of five, backpressure, in-order launch (all time out)
        new_test(0, 0);
        launched.delete();
        for (int i = 0; i < 5; i++) begin
            wr_valid_i = 1;
            case (i)
                0: wr_data_i = 3'd1;
                1: wr_data_i = 3'd2;
                2: wr_data_i = 3'd3;
                3: wr_data_i = 3'd4;
                default: wr_data_i = 3'd6;
            endcase
            if (i == 4) begin
                check("t2_count_c4", int'(fifo_count_o), 3);
                check("t2_ready_c4", int'(wr_ready_o), 1);
            end
            tick();
        end
        check("t2_count_peak", int'(fifo_count_o), 4);
        check("t2_ready_full", int'(wr_ready_o), 0);
        wr_data_i = 3'd7;        // refused: FIFO full
        tick();
        wr_valid_i = 0;
        check("t2_count_held", int'(fifo_count_o), 4);
        wait_idle("t2_drain");
        check("t2_n_launched", launched.size(), 5);
        if (launched.size() == 5) begin
            check("t2_w0", launched[0], 1);
            check("t2_w1", launched[1], 2);
            check("t2_w2", launched[2], 3);
            check("t2_w3", launched[3], 4);
            check("t2_w4", launched[4], 6);
        end

        // 3: timeout, next queued word follows two cycles later
        new_test(0, 0);
        wr_valid_i = 1; wr_data_i = 3'd3;
        tick(); wr_data_i = 3'd4;
        tick(); wr_valid_i = 0;
        goto(16); check("t3_to_c16", int'(timeout_o), 0);
        goto(17); check("t3_to_c17", int'(timeout_o), 1);
        goto(18); check("t3_to_c18", int'(timeout_o), 0);
        check("t3_en_c18", int'(sync_en_o), 0);
        goto(19); check("t3_en_c19", int'(sync_en_o), 1);
        check("t3_d_c19", int'(sync_d_o), 4);
        wait_idle("t3_drain");

        // 4: done on the timeout cycle wins
        new_test(10, 0);
        wr_valid_i = 1; wr_data_i = 3'd2;
        tick(); wr_valid_i = 0;
        goto(17); check("t4_no_to", int'(timeout_o), 0);
        check("t4_busy_gap", int'(busy_o), 1);
        goto(18); check("t4_busy_idle", int'(busy_o), 0);
        check("t4_no_to_c18", int'(timeout_o), 0);
        wait_idle("t4_drain");

        // 5: done held high through LAUNCH does not cut the hold short
        new_test(0, 1);
        wr_valid_i = 1; wr_data_i = 3'd6;
        tick(); wr_valid_i = 0;
        goto(5); check("t5_en_c5", int'(sync_en_o), 1);
        goto(6); check("t5_en_c6", int'(sync_en_o), 0);
        goto(7); check("t5_busy_gap", int'(busy_o), 1);
        goto(8); check("t5_busy_idle", int'(busy_o), 0);
        new_test(0, 0);
        wait_idle("t5_drain");

        // 6: reset during LAUNCH with two words queued
        new_test(0, 0);
        wr_valid_i = 1; wr_data_i = 3'd1;
        tick(); wr_data_i = 3'd2;
        tick(); wr_data_i = 3'd3;
        tick(); wr_valid_i = 0;
        check("t6_en_c3", int'(sync_en_o), 1);
        check("t6_count_c3", int'(fifo_count_o), 2);
        reset_n = 0;
        tick(); reset_n = 1;
        check("t6_rst_en", int'(sync_en_o), 0);
        check("t6_rst_d", int'(sync_d_o), 0);
        check("t6_rst_count", int'(fifo_count_o), 0);
        check("t6_rst_busy", int'(busy_o), 0);
        check("t6_rst_to", int'(timeout_o), 0);
        done_delay = 3;
        wr_valid_i = 1; wr_data_i = 3'd5;
        tick(); wr_valid_i = 0;
        check("t6_en_c6", int'(sync_en_o), 0);
        goto(7); check("t6_en_c7", int'(sync_en_o), 1);
        check("t6_d_c7", int'(sync_d_o), 5);
        wait_idle("t6_drain");

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
